// File: rtl/banco_reg_pkg.sv
// Shared constants and types for the banco_reg register bank.
package banco_reg_pkg;

  localparam int unsigned REG_ZERO      = 0;
  localparam int unsigned NREGS_DEFAULT = 32;
  localparam int unsigned AW_DEFAULT    = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dump_state_t;

endpackage

// File: rtl/banco_reg_dump_seq.sv
// Dump sequencer: walks indices 0..NREGS-1 once per DumpStart and registers
// each register value as it goes. The parent supplies rd_data_i = reg[rd_idx_c]
// from the pre-write array, so a same-edge write is never seen by the dump.
module banco_reg_dump_seq
  import banco_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREGS = NREGS_DEFAULT,
  parameter int unsigned AW    = AW_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] rd_data_i,
  output logic [AW-1:0]    rd_idx_c,
  output logic             busy_o,
  output logic             valid_o,
  output logic [AW-1:0]    idx_o,
  output logic [WIDTH-1:0] data_o
);

  localparam int unsigned LAST_IDX = NREGS - 1;

  dump_state_t      state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  // Next-state, index and beat computation; a beat is visible while in RUN.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    busy_d   = 1'b0;
    rd_idx_c = '0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = RUN;
          rd_idx_c = '0;
          idx_d    = '0;
          data_d   = rd_data_i;
          valid_d  = 1'b1;
          busy_d   = 1'b1;
        end
      end
      RUN: begin
        if (idx_q == AW'(LAST_IDX)) begin
          // Last beat has been shown; counter stays at NREGS-1.
          state_d = DONE;
        end else begin
          rd_idx_c = idx_q + AW'(1);
          idx_d    = rd_idx_c;
          data_d   = rd_data_i;
          valid_d  = 1'b1;
          busy_d   = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign busy_o  = busy_q;
  assign valid_o = valid_q;
  assign idx_o   = idx_q;
  assign data_o  = data_q;

endmodule

// File: rtl/banco_reg_leitura.sv
// 32 x WIDTH register bank for the multicycle MIPS datapath: two registered
// read ports, one write port, and a sequential dump engine.
// Optional macro BANCO_REG_BYPASS_EN: forward same-edge write data to reads.
module banco_reg_leitura
  import banco_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREGS = NREGS_DEFAULT,
  parameter int unsigned AW    = AW_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWrite,
  input  logic [AW-1:0]    WriteReg,
  input  logic [WIDTH-1:0] WriteData,
  input  logic             ReadEn,
  input  logic [AW-1:0]    ReadReg1,
  input  logic [AW-1:0]    ReadReg2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2,
  output logic             ReadValid,
  input  logic             DumpStart,
  output logic             DumpBusy,
  output logic             DumpValid,
  output logic [AW-1:0]    DumpIdx,
  output logic [WIDTH-1:0] DumpData
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [WIDTH-1:0] rd1_q, rd1_d;
  logic [WIDTH-1:0] rd2_q, rd2_d;
  logic             rvalid_q, rvalid_d;
  logic [WIDTH-1:0] rd1_c, rd2_c;
  logic [AW-1:0]    dump_idx_c;
  logic [WIDTH-1:0] dump_data_c;

  // Array update; register 0 is never written.
  always_comb begin
    regs_d = regs_q;
    if (RegWrite && (WriteReg != AW'(REG_ZERO))) begin
      regs_d[WriteReg] = WriteData;
    end
    regs_d[0] = '0;
  end

  // Read port muxes, with optional write-to-read forwarding.
  always_comb begin
    rd1_c = regs_q[ReadReg1];
    rd2_c = regs_q[ReadReg2];
`ifdef BANCO_REG_BYPASS_EN
    if (RegWrite && (WriteReg == ReadReg1) && (ReadReg1 != AW'(REG_ZERO))) begin
      rd1_c = WriteData;
    end
    if (RegWrite && (WriteReg == ReadReg2) && (ReadReg2 != AW'(REG_ZERO))) begin
      rd2_c = WriteData;
    end
`endif
  end

  // Read data holds until the next accepted ReadEn; valid is a one-cycle pulse.
  always_comb begin
    rd1_d    = rd1_q;
    rd2_d    = rd2_q;
    rvalid_d = ReadEn;
    if (ReadEn) begin
      rd1_d = rd1_c;
      rd2_d = rd2_c;
    end
  end

  // Dump engine samples the pre-write array through an index mux.
  always_comb begin
    dump_data_c = regs_q[dump_idx_c];
  end

  // Register array and read-port registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
      rd1_q    <= '0;
      rd2_q    <= '0;
      rvalid_q <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= regs_d[i];
      end
      rd1_q    <= rd1_d;
      rd2_q    <= rd2_d;
      rvalid_q <= rvalid_d;
    end
  end

  banco_reg_dump_seq #(
    .WIDTH (WIDTH),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_dump_seq (
    .clk       (clk),
    .rst_n     (reset),
    .start_i   (DumpStart),
    .rd_data_i (dump_data_c),
    .rd_idx_c  (dump_idx_c),
    .busy_o    (DumpBusy),
    .valid_o   (DumpValid),
    .idx_o     (DumpIdx),
    .data_o    (DumpData)
  );

  assign ReadData1 = rd1_q;
  assign ReadData2 = rd2_q;
  assign ReadValid = rvalid_q;

endmodule

// File: tb/tb_banco_reg_leitura.sv
// Directed self-checking bench for banco_reg_leitura.
module tb_banco_reg_leitura;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned AW    = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             RegWrite;
  logic [AW-1:0]    WriteReg;
  logic [WIDTH-1:0] WriteData;
  logic             ReadEn;
  logic [AW-1:0]    ReadReg1;
  logic [AW-1:0]    ReadReg2;
  logic [WIDTH-1:0] ReadData1;
  logic [WIDTH-1:0] ReadData2;
  logic             ReadValid;
  logic             DumpStart;
  logic             DumpBusy;
  logic             DumpValid;
  logic [AW-1:0]    DumpIdx;
  logic [WIDTH-1:0] DumpData;

  int checks = 0;
  int errors = 0;

  banco_reg_leitura dut (
    .clk       (clk),
    .reset     (reset),
    .RegWrite  (RegWrite),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .ReadEn    (ReadEn),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .ReadData1 (ReadData1),
    .ReadData2 (ReadData2),
    .ReadValid (ReadValid),
    .DumpStart (DumpStart),
    .DumpBusy  (DumpBusy),
    .DumpValid (DumpValid),
    .DumpIdx   (DumpIdx),
    .DumpData  (DumpData)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    RegWrite  = 1'b0;
    WriteReg  = '0;
    WriteData = '0;
    ReadEn    = 1'b0;
    ReadReg1  = '0;
    ReadReg2  = '0;
    DumpStart = 1'b0;
  endtask

  task automatic test_reset();
    logic [WIDTH+2+AW+WIDTH+WIDTH+WIDTH-1:0] all_out;
    reset = 1'b0;
    idle_inputs();
    cyc();
    all_out = {ReadValid, DumpBusy, DumpValid, DumpIdx, DumpData, ReadData1, ReadData2};
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_state got %h want 0", all_out);
    end
    reset = 1'b1;
    cyc();
    // Put a value on the read port, then reset in mid-cycle.
    RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'h0000_0055;
    cyc();
    RegWrite = 1'b0; ReadEn = 1'b1; ReadReg1 = 5'd3; ReadReg2 = 5'd3;
    cyc();
    ReadEn = 1'b0;
    checks++;
    if (ReadData1 !== 32'h0000_0055 || ReadValid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_read got %h/%b want 00000055/1", ReadData1, ReadValid);
    end
    #2 reset = 1'b0;
    #1;
    all_out = {ReadValid, DumpBusy, DumpValid, DumpIdx, DumpData, ReadData1, ReadData2};
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL async_reset got %h want 0", all_out);
    end
    #1 reset = 1'b1;
    for (int i = 1; i < 32; i += 2) begin
      ReadEn = 1'b1; ReadReg1 = AW'(i); ReadReg2 = AW'(i + 1);
      cyc();
      checks++;
      if (ReadData1 !== '0 || ReadData2 !== '0 || ReadValid !== 1'b1) begin
        errors++;
        $display("FAIL reset_clear r%0d got %h %h v%b want 0 0 v1", i, ReadData1, ReadData2, ReadValid);
      end
    end
    idle_inputs();
    cyc();
  endtask

  task automatic test_basic_rw();
    RegWrite = 1'b1; WriteReg = 5'd8; WriteData = 32'hDEAD_BEEF;
    cyc();
    WriteReg = 5'd9; WriteData = 32'h1234_5678;
    cyc();
    RegWrite = 1'b0; ReadEn = 1'b1; ReadReg1 = 5'd8; ReadReg2 = 5'd9;
    cyc();
    ReadEn = 1'b0; ReadReg1 = 5'd0; ReadReg2 = 5'd0;
    checks++;
    if (ReadData1 !== 32'hDEAD_BEEF || ReadData2 !== 32'h1234_5678 || ReadValid !== 1'b1) begin
      errors++;
      $display("FAIL basic_read got %h %h v%b want deadbeef 12345678 v1", ReadData1, ReadData2, ReadValid);
    end
    cyc();
    checks++;
    if (ReadData1 !== 32'hDEAD_BEEF || ReadData2 !== 32'h1234_5678 || ReadValid !== 1'b0) begin
      errors++;
      $display("FAIL read_hold got %h %h v%b want deadbeef 12345678 v0", ReadData1, ReadData2, ReadValid);
    end
  endtask

  task automatic test_reg_zero();
    RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'hFFFF_FFFF;
    cyc();
    RegWrite = 1'b0; ReadEn = 1'b1; ReadReg1 = 5'd0; ReadReg2 = 5'd0;
    cyc();
    ReadEn = 1'b0;
    checks++;
    if (ReadData1 !== '0 || ReadData2 !== '0 || ReadValid !== 1'b1) begin
      errors++;
      $display("FAIL reg_zero got %h %h v%b want 0 0 v1", ReadData1, ReadData2, ReadValid);
    end
  endtask

  task automatic test_collision();
    logic [WIDTH-1:0] exp_same;
`ifdef BANCO_REG_BYPASS_EN
    exp_same = 32'h0000_0002;
`else
    exp_same = 32'h0000_0001;
`endif
    RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 32'h0000_0001;
    cyc();
    WriteData = 32'h0000_0002; ReadEn = 1'b1; ReadReg1 = 5'd5; ReadReg2 = 5'd5;
    cyc();
    RegWrite = 1'b0; ReadEn = 1'b0;
    checks++;
    if (ReadData1 !== exp_same || ReadData2 !== exp_same) begin
      errors++;
      $display("FAIL collision got %h %h want %h", ReadData1, ReadData2, exp_same);
    end
    ReadEn = 1'b1;
    cyc();
    ReadEn = 1'b0;
    checks++;
    if (ReadData1 !== 32'h0000_0002) begin
      errors++;
      $display("FAIL collision_after got %h want 00000002", ReadData1);
    end
    // Address 0 collision stays zero with or without forwarding.
    RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'hA5A5_A5A5;
    ReadEn = 1'b1; ReadReg1 = 5'd0; ReadReg2 = 5'd5;
    cyc();
    idle_inputs();
    checks++;
    if (ReadData1 !== '0 || ReadData2 !== 32'h0000_0002) begin
      errors++;
      $display("FAIL collision_r0 got %h %h want 0 00000002", ReadData1, ReadData2);
    end
  endtask

  task automatic test_full_dump();
    int n;
    for (int i = 0; i < 32; i++) begin
      RegWrite = 1'b1; WriteReg = AW'(i); WriteData = WIDTH'(i * 32'h11);
      cyc();
    end
    idle_inputs();
    DumpStart = 1'b1;
    cyc();
    DumpStart = 1'b0;
    for (int b = 0; b < 32; b++) begin
      checks++;
      if (DumpValid !== 1'b1 || DumpBusy !== 1'b1 || DumpIdx !== AW'(b) ||
          DumpData !== WIDTH'(b * 32'h11)) begin
        errors++;
        $display("FAIL dump_beat%0d got v%b b%b i%0d %h want v1 b1 i%0d %h",
                 b, DumpValid, DumpBusy, DumpIdx, DumpData, b, WIDTH'(b * 32'h11));
      end
      if (b == 10) DumpStart = 1'b1;
      if (b == 12) begin
        RegWrite = 1'b1; WriteReg = 5'd13; WriteData = 32'h0000_ABCD;
      end
      cyc();
      DumpStart = 1'b0;
      RegWrite  = 1'b0;
    end
    checks++;
    if (DumpBusy !== 1'b0 || DumpValid !== 1'b0 || DumpIdx !== 5'd31 || DumpData !== 32'h0000_020F) begin
      errors++;
      $display("FAIL dump_end got b%b v%b i%0d %h want b0 v0 i31 0000020f",
               DumpBusy, DumpValid, DumpIdx, DumpData);
    end
    // No further beats after completion.
    n = 0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (DumpValid) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL dump_no_wrap got %0d extra beats want 0", n);
    end
    ReadEn = 1'b1; ReadReg1 = 5'd13; ReadReg2 = 5'd31;
    cyc();
    ReadEn = 1'b0;
    checks++;
    if (ReadData1 !== 32'h0000_ABCD || ReadData2 !== 32'h0000_020F) begin
      errors++;
      $display("FAIL dump_write_landed got %h %h want 0000abcd 0000020f", ReadData1, ReadData2);
    end
  endtask

  task automatic test_reset_mid_dump();
    int n;
    idle_inputs();
    DumpStart = 1'b1;
    cyc();
    DumpStart = 1'b0;
    for (int b = 0; b < 7; b++) cyc();
    checks++;
    if (DumpIdx !== 5'd7 || DumpValid !== 1'b1) begin
      errors++;
      $display("FAIL mid_dump_beat7 got i%0d v%b want i7 v1", DumpIdx, DumpValid);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (DumpBusy !== 1'b0 || DumpValid !== 1'b0 || DumpIdx !== '0 || DumpData !== '0) begin
      errors++;
      $display("FAIL mid_dump_reset got b%b v%b i%0d %h want all 0", DumpBusy, DumpValid, DumpIdx, DumpData);
    end
    #1 reset = 1'b1;
    DumpStart = 1'b1;
    cyc();
    DumpStart = 1'b0;
    checks++;
    if (DumpBusy !== 1'b1 || DumpValid !== 1'b1 || DumpIdx !== '0 || DumpData !== '0) begin
      errors++;
      $display("FAIL restart got b%b v%b i%0d %h want b1 v1 i0 0", DumpBusy, DumpValid, DumpIdx, DumpData);
    end
    cyc();
    checks++;
    if (DumpIdx !== 5'd1 || DumpData !== '0) begin
      errors++;
      $display("FAIL restart_beat1 got i%0d %h want i1 0", DumpIdx, DumpData);
    end
    n = 1;
    while (DumpBusy === 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    checks++;
    if (n != 32) begin
      errors++;
      $display("FAIL restart_len got %0d busy cycles want 32", n);
    end
  endtask

  initial begin
    test_reset();
    test_basic_rw();
    test_reg_zero();
    test_collision();
    test_full_dump();
    test_reset_mid_dump();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/banco_reg_leitura.md
Name: banco_reg_leitura

Overview:
- 32 x WIDTH general-purpose register bank for the multicycle MIPS datapath.
- Two registered read ports (rs/rt) and one write port (writeback).
- A sequential dump engine streams every register out, one per cycle, for bench and debug inspection.
- Read ports feed the A/B operand registers; the write port is driven from the MemToReg/RegDst muxes.

Parameters:
WIDTH, 32, data width of each register.
NREGS, 32, number of registers; must be a power of two; register 0 hardwired to zero.
AW, 5, address width; must equal log2(NREGS).

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset.
RegWrite  input  1  write enable.
WriteReg  input  AW  write address.
WriteData  input  WIDTH  write data.
ReadEn  input  1  read strobe; samples both read addresses.
ReadReg1  input  AW  port-1 address (rs).
ReadReg2  input  AW  port-2 address (rt).
ReadData1  output  WIDTH  port-1 data, registered.
ReadData2  output  WIDTH  port-2 data, registered.
ReadValid  output  1  high one cycle after an accepted ReadEn.
DumpStart  input  1  pulse; starts a full-bank dump.
DumpBusy  output  1  dump in progress.
DumpValid  output  1  DumpIdx/DumpData are valid this cycle.
DumpIdx  output  AW  index being dumped.
DumpData  output  WIDTH  contents of register DumpIdx.

Behaviour:
- Reset (reset=0, asynchronous):
  - All registers cleared to 0.
  - ReadData1/2=0, ReadValid=0.
  - DumpBusy=0, DumpValid=0, DumpIdx=0, DumpData=0.
  - Dump FSM returns to IDLE.
  - Takes effect immediately, including mid-dump or mid-read.
- Write: on a clk edge with RegWrite=1 and WriteReg!=0, reg[WriteReg] <= WriteData. Writes to register 0 are ignored.
- Read: on a clk edge with ReadEn=1, ReadData1 <= reg[ReadReg1] and ReadData2 <= reg[ReadReg2]. ReadValid is set to 1 for exactly that next cycle.
  - Latency is 1 cycle.
  - ReadData holds its value until the next accepted ReadEn.
  - ReadEn=0 leaves ReadData unchanged and drives ReadValid=0.
- Register 0 always reads 0.
- Same-edge read and write to the same address:
  - With the bypass feature, the read returns WriteData.
  - Without it, the read returns the old value.
  - Address 0 always returns 0 regardless of bypass.
- Dump FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on DumpStart=1; DumpIdx <= 0, DumpBusy=1.
  - RUN: every cycle, DumpData <= reg[DumpIdx], DumpValid=1, DumpIdx increments.
  - RUN -> DONE after index NREGS-1 has been emitted. There is no wrap-around: the counter stops at NREGS-1.
  - DONE -> IDLE after one cycle; DumpBusy=0 in DONE.
  - DumpStart while busy is ignored.
  - A write to the register currently being dumped on the same edge: the dump shows the old value, since the dump always samples the pre-write array.
  - Dump and normal reads are independent; both may be active in the same cycle.
- DumpValid=0 outside RUN. DumpData holds its last value.

Optional Feature:
- Macro: BANCO_REG_BYPASS_EN.
- Defined: write-to-read forwarding on both read ports, so a same-edge write to the read address returns WriteData.
- Undefined: no forwarding; the read returns the pre-write contents. Saves one comparator and mux per port.

Decomposition:
- Shared package banco_reg_pkg:
  - Constants REG_ZERO=0, NREGS_DEFAULT=32, AW_DEFAULT=5.
  - typedef dump_state_t, an enum of IDLE/RUN/DONE.
- One natural sub-module: banco_reg_dump_seq. It holds the dump FSM and index counter, and receives array data through an index-addressed mux in the parent.

Test Plan:
- Reset check: drive reset=0 mid-run -> all outputs 0 immediately; then read regs 1..31 with ReadEn -> all read 0.
- Basic write/read: write 0xDEADBEEF to r8 and 0x12345678 to r9, then ReadEn with rs=8, rt=9 -> next cycle ReadData1=0xDEADBEEF, ReadData2=0x12345678, ReadValid=1 for one cycle.
- Register zero: write 0xFFFFFFFF to r0, then read r0 on both ports -> 0x00000000.
- Same-edge collision: r5=0x1, then write 0x2 to r5 with ReadEn rs=5 on the same edge -> ReadData1=0x2 with BANCO_REG_BYPASS_EN, 0x1 without.
- Full dump: preload reg[i]=i*0x11, pulse DumpStart -> 32 consecutive DumpValid cycles with DumpIdx 0..31 and DumpData 0,0x11,...,0x20F. DumpBusy falls one cycle after the last beat. A second DumpStart at beat 10 is ignored.
- Reset mid-dump: assert reset=0 at beat 7 -> DumpBusy=0, DumpValid=0, DumpIdx=0 immediately; the next DumpStart restarts from index 0.
